bcd_display_scan: RTL

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

---
 rtl/bcd_display_scan_if.sv | 11 +
 rtl/bcd_display_scan.sv | 94 +++++++++
 2 files changed

// File: rtl/bcd_display_scan_if.sv
// Display-scan bus: BCD buffer load strobe in, multiplexed anode/segment drive out.
interface bcd_display_scan_if;
    logic [11:0] bcd;
    logic        load;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        slot_tick;

    modport master (output bcd, load, input an, seg, slot_tick);
    modport slave  (input bcd, load, output an, seg, slot_tick);
endinterface

// File: rtl/bcd_display_scan.sv
// Three-digit multiplexed 7-segment scanner with per-slot anti-ghosting guard.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on hundreds/tens.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_display_scan_if.slave  bus
);
    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    logic [11:0]   disp_reg, disp_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    idx_reg, idx_next;
    logic [2:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          tick_reg, tick_next;
    logic          wrap, in_guard, blank;
    logic [3:0]    nib;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111; // non-BCD nibble shown as a dash
        endcase
        return s;
    endfunction

    always_comb begin
        wrap      = (cnt_reg == LAST);
        cnt_next  = wrap ? '0 : cnt_reg + CW'(1);
        idx_next  = idx_reg;
        if (wrap)
            idx_next = (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
        disp_next = bus.load ? bus.bcd : disp_reg;
        tick_next = wrap;
        in_guard  = (cnt_reg < GUARD_C);
        case (idx_reg)
            2'd1:    nib = disp_reg[7:4];
            2'd2:    nib = disp_reg[11:8];
            default: nib = disp_reg[3:0];
        endcase
        seg_next = (in_guard || blank) ? 7'h7F : seg_decode(nib);
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = ((idx_reg == 2'd2) && (disp_reg[11:8] == 4'd0)) ||
                   ((idx_reg == 2'd1) && (disp_reg[11:4] == 8'd0));
`else
    assign blank = 1'b0;
`endif

    // One anode per digit; the index compare guarantees at most one is low.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_an
            assign an_next[gi] = in_guard || (idx_reg != 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_reg <= '0;
            cnt_reg  <= '0;
            idx_reg  <= '0;
            an_reg   <= 3'b111;
            seg_reg  <= 7'h7F;
            tick_reg <= 1'b0;
        end else begin
            disp_reg <= disp_next;
            cnt_reg  <= cnt_next;
            idx_reg  <= idx_next;
            an_reg   <= an_next;
            seg_reg  <= seg_next;
            tick_reg <= tick_next;
        end
    end

    assign bus.an        = an_reg;
    assign bus.seg       = seg_reg;
    assign bus.slot_tick = tick_reg;
endmodule
